gfx_frame_regs: RTL and testbench

//  Parametrised, double-buffered register bank for the graphics ASIC. The CPU writes

---
 rtl/gfx_frame_regs.sv | 183 ++++++++++++++++++
 tb/tb_gfx_frame_regs.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_frame_regs.sv
// gfx_frame_regs
// Double-buffered register bank for the graphics ASIC. The CPU writes object
// state into shadow registers; once per VGA frame the whole shadow set is
// copied into the active set in a single clock edge, so renderers reading
// active_regs never observe a partially updated frame.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   chipselect     bank select, this bank responds when chipselect[CS_ID]=1
//   bus_we         write strobe
//   databus        write data
//   data_address   register index for writes
//   rd_addr        register index for shadow readback
//   rd_data        registered shadow readback (0 for indices >= NUM_REGS)
//   VGA_ready      pixel-accept qualifier from the VGA side
//   pixel_address  current scan address
//   commit_hold    1 = drop frame commits while a multi-word update is open
//   active_regs    packed active registers, reg i at [i*DATA_W +: DATA_W]
//   commit_pulse   high for the single cycle after a commit
//   dirty          shadow written since the last commit
//   frame_count    number of commits, wraps
//
// Build option: define GFX_DEMO_SWEEP_EN to turn register 0 into a
// self-sweeping demo value (SWEEP_MIN..SWEEP_MAX+1) that the bus cannot write.
module gfx_frame_regs #(
    parameter int               NUM_REGS       = 16,
    parameter int               DATA_W         = 16,
    parameter int               ADDR_W         = 4,
    parameter int               CS_W           = 4,
    parameter int               CS_ID          = 0,
    parameter int               PIX_W          = 19,
    parameter logic [PIX_W-1:0] FRAME_END_ADDR = 19'h4AFFF,
    parameter int               SWEEP_MIN      = 100,
    parameter int               SWEEP_MAX      = 400
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CS_W-1:0]            chipselect,
    input  logic                       bus_we,
    input  logic [DATA_W-1:0]          databus,
    input  logic [ADDR_W-1:0]          data_address,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    input  logic                       VGA_ready,
    input  logic [PIX_W-1:0]           pixel_address,
    input  logic                       commit_hold,
    output logic [NUM_REGS*DATA_W-1:0] active_regs,
    output logic                       commit_pulse,
    output logic                       dirty,
    output logic [15:0]                frame_count
);

    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0] shadow [NUM_REGS];
    logic [DATA_W-1:0] active [NUM_REGS];
    logic [DATA_W-1:0] rd_mux;
    logic              addr_ok;
    logic              wr_en;
    logic              frame_end;
    logic              frame_end_q;
    logic              commit_req;
    logic              commit;

    assign addr_ok = ({1'b0, data_address} < NUM_REGS_L);

`ifdef GFX_DEMO_SWEEP_EN
    localparam logic [DATA_W-1:0] SWEEP_MIN_V = DATA_W'(SWEEP_MIN);
    localparam logic [DATA_W-1:0] SWEEP_MAX_V = DATA_W'(SWEEP_MAX);
    localparam logic [DATA_W-1:0] REG0_RST    = SWEEP_MIN_V;

    logic [DATA_W-1:0] sweep_next;
    logic              unused_cs;

    // Register 0 belongs to the sweep, so bus writes to it are filtered out
    // before they can touch the shadow or the dirty flag.
    assign wr_en      = chipselect[CS_ID] & bus_we & addr_ok & (data_address != '0);
    assign sweep_next = (active[0] <= SWEEP_MAX_V) ? active[0] + DATA_W'(1) : SWEEP_MIN_V;
    assign unused_cs  = ^chipselect;
`else
    localparam logic [DATA_W-1:0] REG0_RST = '0;

    logic unused_cfg;

    assign wr_en      = chipselect[CS_ID] & bus_we & addr_ok;
    assign unused_cfg = ^{chipselect, DATA_W'(SWEEP_MIN), DATA_W'(SWEEP_MAX)};
`endif

    // A commit request is the first cycle of the frame-end condition, so a
    // condition held for many cycles still yields one request per frame. A
    // held request is simply lost; the next frame end tries again.
    assign frame_end  = VGA_ready & (pixel_address == FRAME_END_ADDR);
    assign commit_req = frame_end & ~frame_end_q;
    assign commit     = commit_req & ~commit_hold;

    // Shadow registers take CPU writes. Under the demo sweep, register 0
    // advances in lockstep with its active copy at each commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= (i == 0) ? REG0_RST : '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && (data_address == ADDR_W'(i))) begin
                    shadow[i] <= databus;
                end
            end
`ifdef GFX_DEMO_SWEEP_EN
            if (commit) begin
                shadow[0] <= sweep_next;
            end
`endif
        end
    end

    // Active registers load the whole shadow set on a commit. A write landing
    // in the commit cycle is forwarded so it is not left behind for a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                active[i] <= (i == 0) ? REG0_RST : '0;
            end
        end else if (commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                active[i] <= (wr_en && (data_address == ADDR_W'(i))) ? databus : shadow[i];
            end
`ifdef GFX_DEMO_SWEEP_EN
            active[0] <= sweep_next;
`endif
        end
    end

    // Frame bookkeeping: edge detector history, commit pulse, dirty flag and
    // frame counter. A commit always clears dirty, even with a write in the
    // same cycle, because that write went straight through to active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_end_q  <= 1'b0;
            commit_pulse <= 1'b0;
            dirty        <= 1'b0;
            frame_count  <= '0;
        end else begin
            frame_end_q  <= frame_end;
            commit_pulse <= commit;
            if (commit) begin
                dirty       <= 1'b0;
                frame_count <= frame_count + 16'd1;
            end else if (wr_en) begin
                dirty <= 1'b1;
            end
        end
    end

    // Readback select; indices past the last register fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_mux = shadow[i];
            end
        end
    end

    // Registered readback port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_mux;
        end
    end

    // Flatten the active array onto the output bus.
    always_comb begin
        active_regs = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            active_regs[i*DATA_W +: DATA_W] = active[i];
        end
    end

endmodule

// File: tb/tb_gfx_frame_regs.sv
// tb_gfx_frame_regs
// Directed bench for gfx_frame_regs with a 12-register bank so that
// out-of-range addresses exist. Expected values are queued as stimulus is
// applied and popped when the matching output is sampled.
module tb_gfx_frame_regs;

    localparam int             NR = 12;
    localparam int             DW = 16;
    localparam logic [18:0]    FE = 19'h4AFFF;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        chipselect;
    logic              bus_we;
    logic [DW-1:0]     databus;
    logic [3:0]        data_address;
    logic [3:0]        rd_addr;
    logic [DW-1:0]     rd_data;
    logic              VGA_ready;
    logic [18:0]       pixel_address;
    logic              commit_hold;
    logic [NR*DW-1:0]  active_regs;
    logic              commit_pulse;
    logic              dirty;
    logic [15:0]       frame_count;

    logic [NR*DW-1:0]  exp_rst;
    int                vectors     = 0;
    int                miscompares = 0;
    int                pulses;
    int                guard;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    gfx_frame_regs #(
        .NUM_REGS (NR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .chipselect    (chipselect),
        .bus_we        (bus_we),
        .databus       (databus),
        .data_address  (data_address),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .VGA_ready     (VGA_ready),
        .pixel_address (pixel_address),
        .commit_hold   (commit_hold),
        .active_regs   (active_regs),
        .commit_pulse  (commit_pulse),
        .dirty         (dirty),
        .frame_count   (frame_count)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Queue an expected value under a tag.
    task automatic expectVal(input string tag, input logic [15:0] v);
        sb_item_t it;
        it.tag = tag;
        it.exp = v;
        sb_q.push_back(it);
    endtask

    // Pop the oldest expectation and compare it with an observed output.
    task automatic checkOutput(input logic [15:0] obs);
        sb_item_t it;
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            it = sb_q.pop_front();
            assert (obs === it.exp) else begin
                miscompares++;
                $error("[TB] FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic checkBit(input logic b);
        checkOutput({15'b0, b});
    endtask

    function automatic logic [15:0] act(input int k);
        return active_regs[k*DW +: DW];
    endfunction

    // One-cycle bus write; the strobe drops again afterwards.
    task automatic applyStimulus(input logic [3:0] cs, input logic [3:0] addr,
                                 input logic [15:0] data);
        chipselect   = cs;
        bus_we       = 1'b1;
        data_address = addr;
        databus      = data;
        tick();
        bus_we       = 1'b0;
        chipselect   = 4'b0;
    endtask

    // One full frame-end event (raise for one cycle, then drop).
    task automatic frameEvent;
        pixel_address = FE;
        VGA_ready     = 1'b1;
        tick();
        VGA_ready     = 1'b0;
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        chipselect    = '0;
        bus_we        = 1'b0;
        databus       = '0;
        data_address  = '0;
        rd_addr       = '0;
        VGA_ready     = 1'b0;
        pixel_address = '0;
        commit_hold   = 1'b0;
        exp_rst       = '0;
`ifdef GFX_DEMO_SWEEP_EN
        exp_rst[15:0] = 16'd100;
`endif
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Pending write, then asynchronous reset in the middle of a cycle.
        applyStimulus(4'b0001, 4'd3, 16'h1234);
        expectVal("dirty_before_reset", 16'd1);
        checkBit(dirty);
        #3 rst = 1'b1;
        #1;
        expectVal("reset_dirty", 16'd0);
        expectVal("reset_commit_pulse", 16'd0);
        expectVal("reset_frame_count", 16'd0);
        expectVal("reset_active_regs", 16'd1);
        expectVal("reset_rd_data", 16'd0);
        checkBit(dirty);
        checkBit(commit_pulse);
        checkOutput(frame_count);
        checkBit(active_regs === exp_rst);
        checkOutput(rd_data);
        #2 rst = 1'b0;
        rd_addr = 4'd3;
        expectVal("discarded_write_rd3", 16'h0000);
        tick();
        tick();
        checkOutput(rd_data);

        // Basic write and commit with frame end held for five cycles.
        applyStimulus(4'b0001, 4'd3, 16'h0150);
        rd_addr = 4'd3;
        expectVal("readback_rd3", 16'h0150);
        expectVal("dirty_after_write", 16'd1);
        tick();
        checkOutput(rd_data);
        checkBit(dirty);
        pixel_address = FE;
        VGA_ready     = 1'b1;
        pulses        = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            pulses += int'(commit_pulse);
            if (i == 0) begin
                expectVal("commit_active3", 16'h0150);
                expectVal("commit_pulse_first", 16'd1);
                expectVal("commit_frame_count", 16'd1);
                expectVal("commit_dirty_clear", 16'd0);
                checkOutput(act(3));
                checkBit(commit_pulse);
                checkOutput(frame_count);
                checkBit(dirty);
            end
        end
        VGA_ready = 1'b0;
        tick();
        pulses += int'(commit_pulse);
        expectVal("one_pulse_per_frame", 16'd1);
        expectVal("one_commit_per_frame", 16'd1);
        checkOutput(16'(pulses));
        checkOutput(frame_count);

        // Deselected and out-of-range writes are ignored.
        applyStimulus(4'b1110, 4'd5, 16'hDEAD);
        applyStimulus(4'b0001, 4'd13, 16'h5555);
        expectVal("ignored_write_dirty", 16'd0);
        checkBit(dirty);
        rd_addr = 4'd5;
        expectVal("ignored_write_rd5", 16'h0000);
        tick();
        checkOutput(rd_data);
        rd_addr = 4'd13;
        expectVal("out_of_range_rd13", 16'h0000);
        expectVal("active3_stable", 16'h0150);
        tick();
        checkOutput(rd_data);
        checkOutput(act(3));

        // commit_hold drops the request; the next frame end commits.
        applyStimulus(4'b0001, 4'd4, 16'h00AA);
        commit_hold   = 1'b1;
        pixel_address = FE;
        VGA_ready     = 1'b1;
        tick();
        expectVal("held_no_pulse_a", 16'd0);
        checkBit(commit_pulse);
        tick();
        expectVal("held_no_pulse_b", 16'd0);
        expectVal("held_active4", 16'h0000);
        expectVal("held_dirty", 16'd1);
        expectVal("held_frame_count", 16'd1);
        checkBit(commit_pulse);
        checkOutput(act(4));
        checkBit(dirty);
        checkOutput(frame_count);
        VGA_ready   = 1'b0;
        commit_hold = 1'b0;
        tick();
        VGA_ready = 1'b1;
        tick();
        expectVal("release_active4", 16'h00AA);
        expectVal("release_pulse", 16'd1);
        expectVal("release_frame_count", 16'd2);
        expectVal("release_dirty", 16'd0);
        checkOutput(act(4));
        checkBit(commit_pulse);
        checkOutput(frame_count);
        checkBit(dirty);
        VGA_ready = 1'b0;
        tick();

        // VGA_ready with a non-final pixel address must not commit.
        pixel_address = FE - 19'd1;
        VGA_ready     = 1'b1;
        tick();
        expectVal("wrong_pixel_no_pulse", 16'd0);
        expectVal("wrong_pixel_frame_count", 16'd2);
        tick();
        checkBit(commit_pulse);
        checkOutput(frame_count);

        // Write landing in the frame-end edge cycle goes through to active.
        pixel_address = FE;
        applyStimulus(4'b0001, 4'd2, 16'hBEEF);
        expectVal("writethrough_active2", 16'hBEEF);
        expectVal("writethrough_dirty", 16'd0);
        expectVal("writethrough_frame_count", 16'd3);
        expectVal("writethrough_pulse", 16'd1);
        checkOutput(act(2));
        checkBit(dirty);
        checkOutput(frame_count);
        checkBit(commit_pulse);
        VGA_ready = 1'b0;
        rd_addr   = 4'd2;
        expectVal("writethrough_rd2", 16'hBEEF);
        expectVal("final_active3", 16'h0150);
        tick();
        checkOutput(rd_data);
        checkOutput(act(3));

`ifdef GFX_DEMO_SWEEP_EN
        // Sweep register: run up to the top of the range and across the wrap.
        expectVal("sweep_after_three", 16'd103);
        checkOutput(act(0));
        guard = 0;
        while ((act(0) != 16'd400) && (guard < 1000)) begin
            frameEvent();
            guard++;
        end
        if (guard >= 1000) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL sweep_timeout observed=%h expected=0190", act(0));
        end
        frameEvent();
        expectVal("sweep_401", 16'd401);
        checkOutput(act(0));
        frameEvent();
        expectVal("sweep_wrap_100", 16'd100);
        checkOutput(act(0));
        applyStimulus(4'b0001, 4'd0, 16'h1234);
        rd_addr = 4'd0;
        expectVal("sweep_bus_write_dirty", 16'd0);
        expectVal("sweep_bus_write_rd0", 16'd100);
        checkBit(dirty);
        tick();
        checkOutput(rd_data);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
